dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder for the MEM stage: byte/half/word loads and
// stores with a 1-cycle response, error detection and load sign/zero extension.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_mem_wren,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byte_num,
  input  logic        i_ld_unsigned,
  output logic        o_ready,
  output logic        o_rvalid,
  output logic [31:0] o_ld_data,
  output logic        o_err
);
  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];

  logic        wren_q, uns_q, err_q;
  logic [1:0]  off_q;
  logic [3:0]  size_q;
  logic [31:0] rd_q, hold_q;

  logic [29:0]   word_idx;
  logic [1:0]    off;
  logic [AW-1:0] mem_idx;
  logic          size_ok, misal, oor, req_err, accept;
  logic [3:0]    wr_lanes;
  logic [31:0]   wdata_sh, rd_sh, fmt, resp_val;

  assign word_idx = i_addr[31:2];
  assign off      = i_addr[1:0];
  assign mem_idx  = word_idx[AW-1:0];

  assign size_ok = (i_byte_num == 4'b0001) || (i_byte_num == 4'b0011) ||
                   (i_byte_num == 4'b1111);
  assign misal   = ((i_byte_num == 4'b0011) && off[0]) ||
                   ((i_byte_num == 4'b1111) && (off != 2'b00));
  assign oor     = {2'b00, word_idx} >= DEPTH_U;
  assign req_err = !size_ok || misal || oor;

  assign o_ready = (state == IDLE) && !i_reset;
  assign accept  = i_req && o_ready;

  // Legal accesses are naturally aligned, so the lane shift never overflows.
  assign wr_lanes = (accept && i_mem_wren && !req_err) ? (i_byte_num << off) : 4'b0000;
  assign wdata_sh = i_wdata << {off, 3'b000};

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_lanes[b]) mem[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      hold_q <= '0;
    end else begin
      case (state)
        IDLE: if (i_req) begin
          state  <= RESP;
          wren_q <= i_mem_wren;
          off_q  <= off;
          size_q <= i_byte_num;
          uns_q  <= i_ld_unsigned;
          err_q  <= req_err;
          if (!i_mem_wren && !req_err) rd_q <= mem[mem_idx];
        end
        RESP: begin
          state  <= IDLE;
          hold_q <= resp_val;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_sh = rd_q >> {off_q, 3'b000};

  always_comb begin
    fmt = rd_sh;
    case (size_q)
      4'b0001: fmt = uns_q ? {24'h0, rd_sh[7:0]}  : {{24{rd_sh[7]}}, rd_sh[7:0]};
      4'b0011: fmt = uns_q ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: fmt = rd_sh;
    endcase
  end

  // Errors zero the load bus; legal stores keep whatever the last load left there.
  assign resp_val = err_q ? 32'h0 : (wren_q ? hold_q : fmt);

  // Gating with reset lets a reset during RESP swallow the pending pulse.
  assign o_rvalid  = (state == RESP) && !i_reset;
  assign o_err     = o_rvalid && err_q;
  assign o_ld_data = o_rvalid ? resp_val : hold_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed literal cases plus a random
// stream compared every cycle against a byte-array reference model.
module tb_dmem_responder;
  localparam int DEPTH = 512;

  logic        i_clk = 1'b0;
  logic        i_reset, i_req, i_mem_wren, i_ld_unsigned;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_byte_num;
  logic        o_ready, o_rvalid, o_err;
  logic [31:0] o_ld_data;

  always #5 i_clk = ~i_clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_mem_wren(i_mem_wren),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_byte_num(i_byte_num),
    .i_ld_unsigned(i_ld_unsigned), .o_ready(o_ready), .o_rvalid(o_rvalid),
    .o_ld_data(o_ld_data), .o_err(o_err)
  );

  int checks = 0, failures = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, one response in flight.
  bit [7:0]    mm [DEPTH*4];
  bit          m_busy = 1'b0, m_err = 1'b0, m_load = 1'b0;
  logic [31:0] m_data = '0, m_held = '0;
  int          n_m;
  bit          bad_m;
  logic [10:0] ba;
  logic [31:0] v_m;

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_busy <= 1'b0;
      m_held <= '0;
    end else if (m_busy) begin
      m_busy <= 1'b0;
      m_held <= m_err ? 32'h0 : (m_load ? m_data : m_held);
    end else if (i_req) begin
      n_m   = (i_byte_num == 4'h1) ? 1 : (i_byte_num == 4'h3) ? 2 : (i_byte_num == 4'hF) ? 4 : 0;
      bad_m = (n_m == 0) || ((i_addr & 32'(n_m - 1)) != 0) || ((i_addr >> 2) >= 32'(DEPTH));
      ba    = i_addr[10:0];
      v_m   = '0;
      if (!bad_m && i_mem_wren)
        for (int k = 0; k < n_m; k++) mm[ba + 11'(k)] <= 8'(i_wdata >> (8*k));
      if (!bad_m && !i_mem_wren) begin
        for (int k = 0; k < n_m; k++) v_m = v_m | (32'(mm[ba + 11'(k)]) << (8*k));
        if (!i_ld_unsigned && n_m < 4 && v_m[8*n_m-1]) v_m = v_m | (32'hFFFF_FFFF << (8*n_m));
      end
      m_busy <= 1'b1;
      m_err  <= bad_m;
      m_load <= !i_mem_wren;
      m_data <= v_m;
    end
  end

  always @(negedge i_clk) begin
    if (run_chk) begin
      chkb("ready", o_ready, !m_busy && !i_reset);
      chkb("rvalid", o_rvalid, m_busy && !i_reset);
      if (m_busy && !i_reset) chkb("err", o_err, m_err);
      chk("ld_data", o_ld_data,
          (m_busy && !i_reset) ? (m_err ? 32'h0 : (m_load ? m_data : m_held)) : m_held);
    end
  end

  logic        r_v, r_e;
  logic [31:0] r_d;

  // Issue one access from IDLE (called just after a rising edge) and capture its response.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] bn, input bit u);
    i_req = 1'b1; i_mem_wren = wr; i_addr = a; i_wdata = wd; i_byte_num = bn; i_ld_unsigned = u;
    @(posedge i_clk); #1;
    i_req = 1'b0; i_mem_wren = 1'($urandom); i_addr = $urandom; i_wdata = $urandom;
    i_byte_num = 4'($urandom); i_ld_unsigned = 1'($urandom);
    @(negedge i_clk);
    r_v = o_rvalid; r_e = o_err; r_d = o_ld_data;
    @(posedge i_clk); #1;
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom % 10)
      0:       return 32'h800 + ($urandom % 256);
      1:       return $urandom;
      default: return $urandom % 64;
    endcase
  endfunction

  function automatic logic [3:0] rsize();
    if ($urandom % 8 < 2) return 4'($urandom);
    case ($urandom % 3)
      0:       return 4'h1;
      1:       return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  int acc_n, rv_n;

  initial begin
    i_reset = 1'b1; i_req = 1'b0; i_mem_wren = 1'b0; i_addr = '0; i_wdata = '0;
    i_byte_num = 4'hF; i_ld_unsigned = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chkb("rst_ready", o_ready, 1'b0);
    chkb("rst_rvalid", o_rvalid, 1'b0);
    chk("rst_ld_data", o_ld_data, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    run_chk = 1'b1;

    // Word round trip, extension, partial store
    access(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    chkb("st_word_rv", r_v, 1'b1); chkb("st_word_err", r_e, 1'b0);
    access(0, 32'h10, 32'h0, 4'hF, 0);
    chkb("ld_word_rv", r_v, 1'b1); chkb("ld_word_err", r_e, 1'b0);
    chk("ld_word", r_d, 32'hDEADBEEF);
    access(0, 32'h13, 32'h0, 4'h1, 0); chk("ld_byte_s", r_d, 32'hFFFFFFDE);
    access(0, 32'h13, 32'h0, 4'h1, 1); chk("ld_byte_u", r_d, 32'h000000DE);
    access(0, 32'h10, 32'h0, 4'h3, 0); chk("ld_half_s", r_d, 32'hFFFFBEEF);
    access(1, 32'h11, 32'h12345677, 4'h1, 0); chkb("st_byte_err", r_e, 1'b0);
    access(0, 32'h10, 32'h0, 4'hF, 0); chk("ld_after_byte", r_d, 32'hDEAD77EF);

    // Error cases
    access(1, 32'h12, 32'hCAFEF00D, 4'hF, 0);
    chkb("st_misal_rv", r_v, 1'b1); chkb("st_misal_err", r_e, 1'b1);
    access(0, 32'h10, 32'h0, 4'hF, 0);
    chkb("ld_prior_err", r_e, 1'b0); chk("ld_prior", r_d, 32'hDEAD77EF);
    access(0, 32'h800, 32'h0, 4'hF, 0);
    chkb("ld_oor_err", r_e, 1'b1); chk("ld_oor_data", r_d, 32'h0);
    access(0, 32'h10, 32'h0, 4'b0111, 0);
    chkb("ld_badsize_err", r_e, 1'b1); chk("ld_badsize_data", r_d, 32'h0);

    // Handshake: request held high for six cycles
    acc_n = 0; rv_n = 0;
    i_req = 1'b1; i_mem_wren = 1'b0; i_addr = 32'h10; i_byte_num = 4'hF; i_ld_unsigned = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      chkb($sformatf("hs_ready_c%0d", c), o_ready, (c % 2) == 0);
      if (o_ready) acc_n++;
      if (o_rvalid) rv_n++;
      @(posedge i_clk); #1;
    end
    i_req = 1'b0;
    chk("hs_accepts", 32'(acc_n), 32'd3);
    chk("hs_rvalids", 32'(rv_n), 32'd3);
    @(posedge i_clk); #1;

    // Reset abort, then a request in the first cycle after reset
    i_req = 1'b1; i_mem_wren = 1'b0; i_addr = 32'h10; i_byte_num = 4'hF;
    @(posedge i_clk); #1;
    i_req = 1'b0; i_reset = 1'b1;
    @(negedge i_clk);
    chkb("abort_rvalid", o_rvalid, 1'b0);
    chkb("abort_ready", o_ready, 1'b0);
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_req = 1'b1; i_addr = 32'h10; i_byte_num = 4'hF; i_mem_wren = 1'b0;
    @(negedge i_clk);
    chkb("post_rst_ready", o_ready, 1'b1);
    chkb("post_rst_rvalid", o_rvalid, 1'b0);
    chk("post_rst_ld", o_ld_data, 32'h0);
    @(posedge i_clk); #1;
    i_req = 1'b0;
    @(negedge i_clk);
    chkb("post_rst_acc_rv", o_rvalid, 1'b1);
    chk("post_rst_acc_ld", o_ld_data, 32'hDEAD77EF);
    @(posedge i_clk); #1;

    // Fill a 16-word window so random loads never see uninitialised memory
    for (int w = 0; w < 16; w++) access(1, 32'(w * 4), $urandom, 4'hF, 0);

    // Random stream: back-to-back requests, changing inputs in RESP, occasional reset
    for (int cyc = 0; cyc < 800; cyc++) begin
      i_req         = ($urandom % 4) != 0;
      i_mem_wren    = 1'($urandom);
      i_addr        = raddr();
      i_wdata       = $urandom;
      i_byte_num    = rsize();
      i_ld_unsigned = 1'($urandom);
      i_reset       = ($urandom % 80) == 0;
      @(posedge i_clk); #1;
    end
    i_req = 1'b0; i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
